divo_8by4_seq: RTL and testbench
================================

# divo_8by4_seq

Sequential unsigned divider: an 8-bit dividend `p` divided by a 4-bit divisor `m` yields an 8-bit quotient `q` and a 4-bit remainder `r`, so that `p = q*m + r` with `r < m`. It is the inverse of the team's 4x4 combinational multiplier (`p = q*m`) and sits beside it in the lab arithmetic datapath. It uses restoring division, one quotient bit per clock, and a start/done handshake.

## Interface
- No parameters; widths are fixed at 8/4.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  request a division; sampled only in IDLE.
- `p`  in  8  dividend, unsigned; latched on the accepted `start`.
- `m`  in  4  divisor, unsigned; latched on the accepted `start`.
- `q`  out  8  quotient, registered.
- `r`  out  4  remainder, registered.
- `busy`  out  1  high while a division is in progress (RUN state).
- `done`  out  1  one-cycle pulse; `q`/`r`/`div0` are valid while it is high.
- `div0`  out  1  divide-by-zero flag for the last completed operation.

## Operation
- States: IDLE, RUN, DONE.
- On a rising edge with `rst_n`=0:
  - state goes to IDLE.
  - `q`=0, `r`=0, `busy`=0, `done`=0, `div0`=0.
  - Internal counter and shift registers clear.
  - Reset overrides `start` and aborts any division in progress; no `done` is issued for the aborted operation.
- IDLE with `start`=1 and `m`!=0:
  - Latch `p` and `m`, clear the 5-bit partial remainder, load bit counter = 7.
  - Go to RUN; `busy`=1.
- IDLE with `start`=1 and `m`=0:
  - No iteration.
  - Go to DONE with `q`=8'hFF, `r`=4'hF, `div0`=1.
- RUN, each cycle:
  - trial = {partial[3:0], dividend[7]} (5 bits); shift the dividend left by 1.
  - If trial >= {1'b0, m}: partial = trial - m and shift quotient bit 1 in.
  - Otherwise: partial = trial and shift 0 in.
  - After the counter = 0 iteration, go to DONE.
- Width rules:
  - The partial remainder is 5 bits internally; its MSB is always 0 after each subtract/restore.
  - `r` is the low 4 bits of the final partial remainder.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=0, `div0` updated (0 for a normal divide).
  - Go to IDLE unconditionally.
- Output holding:
  - `q`, `r` and `div0` update only on the transition into DONE.
  - They hold their values until the next DONE or reset.
  - They do not change during RUN, so an intermediate quotient never appears on the outputs.
- `start` outside IDLE (RUN or DONE) is ignored and is not queued.
- `p`/`m` may change freely after acceptance without affecting the result.

## Timing
- Start is accepted at edge E0.
- Normal divide:
  - `busy` is high after E0 through E8.
  - `q`/`r` update and `done` rises at E9.
  - Latency is 9 cycles from accept to `done`.
- Divide-by-zero: `done`=1 after E1 (latency 1 cycle).
- Back-to-back operation:
  - `start` held high during DONE is ignored.
  - The next accept is at the first edge in IDLE.
  - Minimum spacing is 10 cycles (normal) or 2 cycles (zero divisor).
- `done` and `busy` are never high together.

## Test plan
- `p`=200, `m`=7, 1-cycle `start` -> after 9 cycles `done`=1 for one cycle, `q`=28, `r`=4, `div0`=0; `busy` high for 8 cycles.
- Boundaries, each -> `div0`=0 with the stated result:
  - `p`=255, `m`=1 -> `q`=255, `r`=0.
  - `p`=15, `m`=15 -> `q`=1, `r`=0.
  - `p`=5, `m`=9 -> `q`=0, `r`=5.
  - `p`=0, `m`=3 -> `q`=0, `r`=0.
- `p`=100, `m`=0 -> `done` one cycle after accept, `q`=8'hFF, `r`=4'hF, `div0`=1; the next divide 100/10 -> `q`=10, `r`=0, `div0`=0.
- Start 200/7, then pulse `start` with 9/3 at cycle 4 and change `p`/`m` mid-run -> still `q`=28, `r`=4; no second `done` follows.
- Start 200/7, assert `rst_n`=0 at cycle 5 -> all outputs 0 on the next edge and no `done`; after release, 77/5 -> `q`=15, `r`=2.
- Exhaustive: all 256x15 nonzero-divisor pairs -> check `q*m + r == p` and `r < m`, using the team's 4x4 multiplier model for `q*m` where `q` < 16.

Source files
------------

// File: rtl/divo_8by4_seq.sv
// Sequential 8-by-4 unsigned restoring divider: one quotient bit per clock,
// start/done handshake, registered quotient/remainder/div0 results.
module divo_8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] p,
  input  logic [3:0] m,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [3:0] rem;
  logic [7:0] quot;
  logic [2:0] bit_cnt;
  logic       zero_div;

  logic [4:0] trial;
  logic       trial_ge;
  logic [3:0] rem_next;

  // Whenever trial >= divisor the difference is below the divisor, so it
  // fits in 4 bits and the 5-bit partial remainder's MSB is always zero.
  always_comb begin
    trial    = {rem, dividend[7]};
    trial_ge = (trial >= {1'b0, divisor});
    rem_next = trial[3:0];
    if (trial_ge) begin
      rem_next = trial[3:0] - divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (m == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bit_cnt == 3'd0) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A zero divisor preloads the saturated result so DONE publishes uniformly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dividend <= 8'd0;
      divisor  <= 4'd0;
      rem      <= 4'd0;
      quot     <= 8'd0;
      bit_cnt  <= 3'd0;
      zero_div <= 1'b0;
      q        <= 8'd0;
      r        <= 4'd0;
      div0     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (m != 4'd0) begin
              dividend <= p;
              divisor  <= m;
              rem      <= 4'd0;
              quot     <= 8'd0;
              bit_cnt  <= 3'd7;
              zero_div <= 1'b0;
            end else begin
              rem      <= 4'hF;
              quot     <= 8'hFF;
              zero_div <= 1'b1;
            end
          end
        end
        RUN: begin
          dividend <= {dividend[6:0], 1'b0};
          rem      <= rem_next;
          quot     <= {quot[6:0], trial_ge};
          bit_cnt  <= bit_cnt - 3'd1;
        end
        DONE: begin
          q    <= quot;
          r    <= rem;
          div0 <= zero_div;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divo_8by4_seq.sv
// Self-checking bench for divo_8by4_seq: scoreboard of expected results
// consumed on every done pulse, plus per-scenario timing checks.
module tb_divo_8by4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] p;
  logic [3:0] m;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       div0;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       div0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  divo_8by4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .m     (m),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  // Shift-add model of the team's 4x4 multiplier.
  function automatic int mul4x4(input logic [3:0] a, input logic [3:0] b);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc + (int'(a) << i);
    end
    return acc;
  endfunction

  function automatic exp_t model(input logic [7:0] pv, input logic [3:0] mv);
    exp_t e;
    if (mv == 4'd0) begin
      e.q = 8'hFF;
      e.r = 4'hF;
      e.div0 = 1'b1;
    end else begin
      e.q = 8'(int'(pv) / int'(mv));
      e.r = 4'(int'(pv) % int'(mv));
      e.div0 = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_with_done: busy=%b required 0 while done=1", busy);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done: done=1 q=%0d r=%0d, required no done", q, r);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({q, r, div0} !== e) begin
          errors++;
          $display("[TB] FAIL result: got q=%0d r=%0d div0=%b, required q=%0d r=%0d div0=%b",
                   q, r, div0, e.q, e.r, e.div0);
        end
      end
    end
  end

  task automatic run_div(input logic [7:0] pv, input logic [3:0] mv,
                         output int lat, output int bcnt,
                         output logic [7:0] qo, output logic [3:0] ro);
    bit seen;
    @(negedge clk);
    p = pv;
    m = mv;
    start = 1'b1;
    exp_q.push_back(model(pv, mv));
    @(posedge clk);
    #1;
    start = 1'b0;
    p = 8'($urandom);
    m = 4'($urandom);
    bcnt = (busy === 1'b1) ? 1 : 0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) bcnt++;
    end
    qo = q;
    ro = r;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL timeout: no done within %0d cycles for %0d/%0d", lat, pv, mv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    p = 8'd200;
    m = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({q, r, busy, done, div0} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: q=%0d r=%0d busy=%b done=%b div0=%b, required all 0",
               q, r, busy, done, div0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [7:0] qo;
    logic [3:0] ro;
    run_div(8'd200, 4'd7, lat, bcnt, qo, ro);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d required 9", lat);
    end
    checks++;
    if (bcnt != 8) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d required 8", bcnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || q !== 8'd28 || r !== 4'd4) begin
      errors++;
      $display("[TB] FAIL basic_hold: done=%b q=%0d r=%0d, required done=0 q=28 r=4", done, q, r);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] pt[4] = '{8'd255, 8'd15, 8'd5, 8'd0};
    logic [3:0] mt[4] = '{4'd1, 4'd15, 4'd9, 4'd3};
    logic [7:0] qt[4] = '{8'd255, 8'd1, 8'd0, 8'd0};
    logic [3:0] rt[4] = '{4'd0, 4'd0, 4'd5, 4'd0};
    int lat, bcnt;
    logic [7:0] qo;
    logic [3:0] ro;
    for (int i = 0; i < 4; i++) begin
      run_div(pt[i], mt[i], lat, bcnt, qo, ro);
      checks++;
      if (qo !== qt[i] || ro !== rt[i] || div0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL boundary_%0d: got q=%0d r=%0d div0=%b, required q=%0d r=%0d div0=0",
                 i, qo, ro, div0, qt[i], rt[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic [7:0] qo;
    logic [3:0] ro;
    run_div(8'd100, 4'd0, lat, bcnt, qo, ro);
    checks++;
    if (lat != 1 || bcnt != 0) begin
      errors++;
      $display("[TB] FAIL div0_timing: latency=%0d busy_cycles=%0d, required 1 and 0", lat, bcnt);
    end
    checks++;
    if (qo !== 8'hFF || ro !== 4'hF || div0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div0_result: q=%h r=%h div0=%b, required ff f 1", qo, ro, div0);
    end
    run_div(8'd100, 4'd10, lat, bcnt, qo, ro);
    checks++;
    if (lat != 9 || qo !== 8'd10 || ro !== 4'd0 || div0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_div0: latency=%0d q=%0d r=%0d div0=%b, required 9 10 0 0",
               lat, qo, ro, div0);
    end
  endtask

  task automatic test_ignored_start();
    int ndone, dcyc;
    @(negedge clk);
    p = 8'd200;
    m = 4'd7;
    start = 1'b1;
    exp_q.push_back(model(8'd200, 4'd7));
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    dcyc = -1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3) begin
        start = 1'b1;
        p = 8'd9;
        m = 4'd3;
      end
      if (cyc == 4) begin
        start = 1'b0;
        p = 8'hAA;
        m = 4'h2;
      end
      if (done === 1'b1) begin
        ndone++;
        dcyc = cyc;
      end
    end
    checks++;
    if (ndone != 1 || dcyc != 9) begin
      errors++;
      $display("[TB] FAIL ignored_start: %0d done pulses, last at cycle %0d, required 1 at cycle 9",
               ndone, dcyc);
    end
  endtask

  task automatic test_reset_abort();
    int ndone, lat, bcnt;
    logic [7:0] qo;
    logic [3:0] ro;
    @(negedge clk);
    p = 8'd200;
    m = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({q, r, busy, done, div0} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL abort_reset: q=%0d r=%0d busy=%b done=%b div0=%b, required all 0",
               q, r, busy, done, div0);
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("[TB] FAIL abort_activity: %0d cycles with busy/done after reset, required 0", ndone);
    end
    run_div(8'd77, 4'd5, lat, bcnt, qo, ro);
    checks++;
    if (lat != 9 || qo !== 8'd15 || ro !== 4'd2) begin
      errors++;
      $display("[TB] FAIL after_abort: latency=%0d q=%0d r=%0d, required 9 15 2", lat, qo, ro);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nd;
    // Normal divides with start held high: accepts at E0 and E10.
    @(negedge clk);
    p = 8'd200;
    m = 4'd7;
    start = 1'b1;
    exp_q.push_back(model(8'd200, 4'd7));
    exp_q.push_back(model(8'd200, 4'd7));
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    nd = 0;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 19) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    checks++;
    if (nd != 2 || d1 != 9 || d2 != 19) begin
      errors++;
      $display("[TB] FAIL b2b_normal: %0d dones at cycles %0d,%0d, required 2 at 9,19", nd, d1, d2);
    end
    repeat (12) @(posedge clk);
    // Zero-divisor back to back: accepts at E0 and E2.
    @(negedge clk);
    p = 8'd50;
    m = 4'd0;
    start = 1'b1;
    exp_q.push_back(model(8'd50, 4'd0));
    exp_q.push_back(model(8'd50, 4'd0));
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    nd = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    checks++;
    if (nd != 2 || d1 != 1 || d2 != 3) begin
      errors++;
      $display("[TB] FAIL b2b_div0: %0d dones at cycles %0d,%0d, required 2 at 1,3", nd, d1, d2);
    end
  endtask

  task automatic test_exhaustive();
    int lat, bcnt, prod;
    logic [7:0] qo;
    logic [3:0] ro;
    for (int pv = 0; pv < 256; pv++) begin
      for (int mv = 1; mv < 16; mv++) begin
        run_div(8'(pv), 4'(mv), lat, bcnt, qo, ro);
        if (qo < 8'd16) prod = mul4x4(qo[3:0], 4'(mv));
        else prod = int'(qo) * mv;
        checks++;
        if (prod + int'(ro) != pv || int'(ro) >= mv) begin
          errors++;
          $display("[TB] FAIL identity: %0d/%0d gave q=%0d r=%0d, required q*m+r=p and r<m",
                   pv, mv, qo, ro);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p = 8'd0;
    m = 4'd0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_exhaustive();
    repeat (12) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d results pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
